// File: rtl/packet_downconverter_if.sv
// rtl/packet_downconverter_if.sv - beat-in / word-out stream bundle for the packet downconverter
interface packet_downconverter_if #(
    parameter int INPUT_WIDTH  = 64,
    parameter int OUTPUT_WIDTH = 32,
    parameter int LEN_WIDTH    = 14
);
    logic                    ivalid;
    logic                    iready;
    logic                    isop;
    logic                    ieop;
    logic [2:0]              iresidual;
    logic [INPUT_WIDTH-1:0]  idata;
    logic                    ibad;
    logic                    ovalid;
    logic                    oready;
    logic                    osop;
    logic                    oeop;
    logic [1:0]              oresidual;
    logic [OUTPUT_WIDTH-1:0] odata;
    logic                    obad;
    logic [LEN_WIDTH-1:0]    oplen;
    logic                    ocpu_interrupt;

    modport slave (
        input  ivalid, isop, ieop, iresidual, idata, ibad, oready,
        output iready, ovalid, osop, oeop, oresidual, odata, obad, oplen, ocpu_interrupt
    );

    modport master (
        output ivalid, isop, ieop, iresidual, idata, ibad, oready,
        input  iready, ovalid, osop, oeop, oresidual, odata, obad, oplen, ocpu_interrupt
    );
endinterface

// File: rtl/packet_downconverter.sv
// rtl/packet_downconverter.sv - 64-to-32 bit packet width reducer, upper half first
module packet_downconverter #(
    parameter int INPUT_WIDTH  = 64,
    parameter int OUTPUT_WIDTH = 32,
    parameter int LEN_WIDTH    = 14
) (
    input  logic                  iclk,
    input  logic                  irst_n,
    packet_downconverter_if.slave bus
);
    typedef enum logic [0:0] {S_IDLE = 1'b0, S_PKT = 1'b1} state_t;

    localparam logic [LEN_WIDTH:0] LEN_MAX = {1'b0, {LEN_WIDTH{1'b1}}};

    state_t                 state, state_nxt;
    logic [INPUT_WIDTH-1:0] hold_data;
    logic                   hold_sop, hold_eop, hold_bad;
    logic [2:0]             hold_res;
    logic                   half, hold_valid;
    logic [LEN_WIDTH-1:0]   byte_cnt;
    logic                   err_no_sop, err_sop_in_pkt;

    logic                   last_half, out_fire, in_fire;
    logic                   keep_beat, flag_no_sop, flag_sop_in_pkt;
    logic [2:0]             word_bytes;
    logic [LEN_WIDTH-1:0]   len_base, len_sat;
    logic [LEN_WIDTH:0]     len_sum;

    // A short EOP beat (1..4 bytes) ends on its upper word.
    assign last_half = half | (hold_eop & (hold_res >= 3'd1) & (hold_res <= 3'd4));
    assign out_fire  = hold_valid & bus.oready;
    assign in_fire   = bus.ivalid & bus.iready;

    assign bus.iready = ~hold_valid | (out_fire & last_half);
    assign bus.ovalid = hold_valid;
    assign bus.odata  = half ? hold_data[OUTPUT_WIDTH-1:0]
                             : hold_data[INPUT_WIDTH-1:OUTPUT_WIDTH];
    assign bus.osop   = hold_valid & hold_sop & ~half;
    assign bus.oeop   = hold_valid & hold_eop & last_half;
    assign bus.obad   = hold_bad & bus.oeop;
    assign bus.ocpu_interrupt = err_no_sop | err_sop_in_pkt;

    always_comb begin
        word_bytes = 3'd4;
        if (bus.oeop) begin
            if (!half)
                word_bytes = (hold_res == 3'd4) ? 3'd4 : hold_res;
            else
                word_bytes = (hold_res == 3'd0) ? 3'd4 : 3'(hold_res - 3'd4);
        end
    end

    // The first word of a packet restarts the count, so a packet cut short by a
    // stray SOP never leaks its bytes into the next length.
    always_comb begin
        len_base = bus.osop ? '0 : byte_cnt;
        len_sum  = {1'b0, len_base} + {{(LEN_WIDTH-2){1'b0}}, word_bytes};
        len_sat  = (len_sum > LEN_MAX) ? {LEN_WIDTH{1'b1}} : len_sum[LEN_WIDTH-1:0];
    end

    assign bus.oplen     = bus.oeop ? len_sat : '0;
    assign bus.oresidual = bus.oeop ? word_bytes[1:0] : 2'd0;

    always_ff @(posedge iclk) begin
        if (!irst_n)
            byte_cnt <= '0;
        else if (out_fire)
            byte_cnt <= bus.oeop ? '0 : len_sat;
    end

    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            hold_data  <= '0;
            hold_sop   <= 1'b0;
            hold_eop   <= 1'b0;
            hold_bad   <= 1'b0;
            hold_res   <= 3'd0;
            half       <= 1'b0;
            hold_valid <= 1'b0;
        end else if (in_fire && keep_beat) begin
            hold_data  <= bus.idata;
            hold_sop   <= bus.isop;
            hold_eop   <= bus.ieop;
            hold_bad   <= bus.ibad;
            hold_res   <= bus.iresidual;
            half       <= 1'b0;
            hold_valid <= 1'b1;
        end else if (out_fire) begin
            if (last_half)
                hold_valid <= 1'b0;
            else
                half <= 1'b1;
        end
    end

    always_ff @(posedge iclk) begin
        if (!irst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (in_fire) begin
            case (state)
                S_IDLE:  if (bus.isop && !bus.ieop) state_nxt = S_PKT;
                S_PKT:   if (bus.ieop) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        keep_beat       = 1'b1;
        flag_no_sop     = 1'b0;
        flag_sop_in_pkt = 1'b0;
        case (state)
            S_IDLE: begin
                keep_beat   = bus.isop;
                flag_no_sop = ~bus.isop;
            end
            S_PKT:   flag_sop_in_pkt = bus.isop;
            default: keep_beat = 1'b0;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            err_no_sop     <= 1'b0;
            err_sop_in_pkt <= 1'b0;
        end else if (in_fire) begin
            if (flag_no_sop)     err_no_sop     <= 1'b1;
            if (flag_sop_in_pkt) err_sop_in_pkt <= 1'b1;
        end
    end

    property p_out_stable;
        @(posedge iclk) disable iff (!irst_n)
        (bus.ovalid && !bus.oready) |=>
            (bus.ovalid && $stable(bus.odata) && $stable(bus.osop) && $stable(bus.oeop)
             && $stable(bus.oresidual) && $stable(bus.oplen) && $stable(bus.obad));
    endproperty
    a_out_stable: assert property (p_out_stable);
endmodule

// File: tb/tb_packet_downconverter.sv
// tb/tb_packet_downconverter.sv - randomized scoreboard bench for packet_downconverter
module tb_packet_downconverter;
    localparam int IW = 64;
    localparam int OW = 32;
    localparam int LW = 14;

    logic iclk   = 1'b0;
    logic irst_n = 1'b0;
    always #5 iclk = ~iclk;

    packet_downconverter_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .LEN_WIDTH(LW)) ifc ();

    packet_downconverter #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .LEN_WIDTH(LW)) dut (
        .iclk   (iclk),
        .irst_n (irst_n),
        .bus    (ifc.slave)
    );

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  res;
        logic        bad;
        int          len;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [63:0] pkt_data[8];
    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          fire_count = 0;
    int          first_fire = 0;
    int          last_fire = 0;
    int          rdy_mode = 0;
    logic        stalled = 1'b0;
    logic [31:0] stall_data = '0;

    always @(posedge iclk) cycle++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Expected words come from the packet viewed as a flat big-endian byte stream.
    task automatic model_push(input int nb, input int res, input bit bad, input bit has_eop);
        int   n, nw, k;
        exp_t w;
        n  = has_eop ? 8 * (nb - 1) + ((res == 0) ? 8 : res) : 8 * nb;
        nw = (n + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            for (int j = 0; j < 4; j++) begin
                k = 4 * i + j;
                w.data[31 - 8*j -: 8] = pkt_data[k/8][63 - 8*(k%8) -: 8];
            end
            w.sop = (i == 0);
            w.eop = has_eop && (i == nw - 1);
            w.res = w.eop ? 2'(n % 4) : 2'd0;
            w.bad = bad & w.eop;
            w.len = n;
            exp_q.push_back(w);
        end
    endtask

    task automatic send_beat(input logic [63:0] d, input bit sop, input bit eop,
                             input logic [2:0] res, input bit bad);
        int n;
        ifc.ivalid    = 1'b1;
        ifc.idata     = d;
        ifc.isop      = sop;
        ifc.ieop      = eop;
        ifc.iresidual = res;
        ifc.ibad      = bad;
        n = 0;
        forever begin
            @(negedge iclk);
            if (ifc.iready) break;
            n++;
            if (n > 1000) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got iready 0, expected 1 within 1000 cycles");
                ifc.ivalid = 1'b0;
                return;
            end
        end
        @(posedge iclk);
        #1;
        ifc.ivalid = 1'b0;
    endtask

    task automatic send_packet(input int nb, input int res, input bit bad, input bit rnd);
        if (rnd)
            for (int b = 0; b < nb; b++) pkt_data[b] = {$urandom, $urandom};
        model_push(nb, res, bad, 1'b1);
        for (int b = 0; b < nb; b++) begin
            if (b == nb - 1)
                send_beat(pkt_data[b], b == 0, 1'b1, 3'(res), bad);
            else
                send_beat(pkt_data[b], b == 0, 1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge iclk);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge iclk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge iclk);
        #1 irst_n = 1'b0;
        repeat (2) @(posedge iclk);
        #1 irst_n = 1'b1;
        #1;
    endtask

    always @(negedge iclk) begin
        if (!irst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_ovalid", 64'(ifc.ovalid), 64'd1);
                check("stall_odata", 64'(ifc.odata), 64'(stall_data));
            end
            if (ifc.ovalid && ifc.oready) begin
                fire_count++;
                last_fire = cycle;
                if (fire_count == 1) first_fire = cycle;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h, expected no word", ifc.odata);
                end else begin
                    e = exp_q.pop_front();
                    check("odata", 64'(ifc.odata), 64'(e.data));
                    check("osop", 64'(ifc.osop), 64'(e.sop));
                    check("oeop", 64'(ifc.oeop), 64'(e.eop));
                    check("oresidual", 64'(ifc.oresidual), 64'(e.res));
                    check("obad", 64'(ifc.obad), 64'(e.bad));
                    if (e.eop) check("oplen", 64'(ifc.oplen), 64'(e.len));
                end
            end
            if (ifc.ovalid && !ifc.oready) check("iready_stall", 64'(ifc.iready), 64'd0);
            stalled    = ifc.ovalid & ~ifc.oready;
            stall_data = ifc.odata;
        end
    end

    initial begin
        ifc.oready = 1'b1;
        forever begin
            @(posedge iclk);
            #1;
            case (rdy_mode)
                0:       ifc.oready = 1'b1;
                1:       ifc.oready = ~ifc.oready;
                2:       ifc.oready = ($urandom_range(0, 3) != 0);
                default: ;
            endcase
        end
    end

    initial begin
        ifc.ivalid    = 1'b0;
        ifc.isop      = 1'b0;
        ifc.ieop      = 1'b0;
        ifc.iresidual = 3'd0;
        ifc.idata     = '0;
        ifc.ibad      = 1'b0;
        repeat (3) @(posedge iclk);
        #1 irst_n = 1'b1;
        #1;
        check("rst_ovalid", 64'(ifc.ovalid), 64'd0);
        check("rst_iready", 64'(ifc.iready), 64'd1);
        check("rst_odata", 64'(ifc.odata), 64'd0);
        check("rst_flags", 64'({ifc.osop, ifc.oeop, ifc.obad, ifc.oresidual}), 64'd0);
        check("rst_oplen", 64'(ifc.oplen), 64'd0);
        check("rst_irq", 64'(ifc.ocpu_interrupt), 64'd0);

        // 16-byte packet at full rate
        fire_count = 0;
        send_packet(2, 0, 1'b0, 1'b1);
        wait_drain();
        check("p16_words", 64'(fire_count), 64'd4);
        check("p16_back_to_back", 64'(last_fire - first_fire), 64'd3);

        // single-beat 3-byte packet
        pkt_data[0] = 64'hAABBCCDD_11223344;
        send_packet(1, 3, 1'b0, 1'b0);
        @(negedge iclk);
        check("single_iready", 64'(ifc.iready), 64'd1);
        wait_drain();

        // 22-byte bad packet
        fire_count = 0;
        send_packet(3, 6, 1'b1, 1'b1);
        wait_drain();
        check("p22_words", 64'(fire_count), 64'd6);

        // alternating backpressure
        rdy_mode = 1;
        fire_count = 0;
        send_packet(2, 0, 1'b0, 1'b1);
        wait_drain();
        check("toggle_words", 64'(fire_count), 64'd4);
        rdy_mode = 0;
        repeat (2) @(posedge iclk);
        #1;

        // beat without SOP is dropped and latches the interrupt
        fire_count = 0;
        send_beat({$urandom, $urandom}, 1'b0, 1'b1, 3'd0, 1'b0);
        repeat (5) @(posedge iclk);
        @(negedge iclk);
        check("nosop_irq", 64'(ifc.ocpu_interrupt), 64'd1);
        check("nosop_no_output", 64'(fire_count), 64'd0);
        repeat (10) @(posedge iclk);
        @(negedge iclk);
        check("nosop_irq_sticky", 64'(ifc.ocpu_interrupt), 64'd1);
        do_reset();
        check("irq_cleared", 64'(ifc.ocpu_interrupt), 64'd0);

        // SOP inside a packet restarts framing
        pkt_data[0] = {$urandom, $urandom};
        model_push(1, 0, 1'b0, 1'b0);
        send_beat(pkt_data[0], 1'b1, 1'b0, 3'd0, 1'b0);
        pkt_data[0] = {$urandom, $urandom};
        model_push(1, 0, 1'b0, 1'b1);
        send_beat(pkt_data[0], 1'b1, 1'b1, 3'd0, 1'b0);
        wait_drain();
        check("sop_in_pkt_irq", 64'(ifc.ocpu_interrupt), 64'd1);
        do_reset();

        // reset after the upper word of a packet
        rdy_mode = 3;
        @(posedge iclk);
        #2 ifc.oready = 1'b0;
        pkt_data[0] = {$urandom, $urandom};
        model_push(1, 0, 1'b0, 1'b0);
        void'(exp_q.pop_back());
        send_beat(pkt_data[0], 1'b1, 1'b0, 3'd0, 1'b0);
        ifc.oready = 1'b1;
        @(posedge iclk);
        #1;
        ifc.oready = 1'b0;
        irst_n = 1'b0;
        @(posedge iclk);
        #1;
        check("midrst_ovalid", 64'(ifc.ovalid), 64'd0);
        check("midrst_queue", 64'(exp_q.size()), 64'd0);
        irst_n = 1'b1;
        rdy_mode = 0;
        send_packet(2, 0, 1'b0, 1'b1);
        wait_drain();

        // randomized traffic and backpressure
        rdy_mode = 2;
        for (int p = 0; p < 40; p++) begin
            send_packet($urandom_range(1, 6), $urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'b1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge iclk);
            #1;
        end
        wait_drain();
        check("final_irq", 64'(ifc.ocpu_interrupt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
